// File: rtl/sca_blk_alloc.sv
// sca_blk_alloc: SCA next-block allocator with free-list FIFO, in-use bitmap and LCT boundary delay.
module sca_blk_alloc #(
    parameter int NBLK      = 16,
    parameter int AW        = 4,
    parameter int LCT_DLY   = 3,
    parameter int AFULL_THR = 2
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            ENAREG,
    input  logic            HOLD,
    input  logic            REL_VLD,
    input  logic [AW-1:0]   REL_ADR,
    output logic [AW-1:0]   WADR,
    output logic [AW-1:0]   LCTADR,
    output logic [AW:0]     NFREE,
    output logic            SCAFULL,
    output logic            ALMOST_FULL,
    output logic            DSCAFULL,
    output logic            READY,
    output logic            REL_ERR,
    output logic [NBLK-1:0] BUSY_MAP
);
    typedef enum logic {S_INIT, S_RUN} state_t;
    state_t r_state, w_state_nxt;
    logic [AW-1:0] r_fifo [NBLK];
    logic [AW-1:0] r_lct [LCT_DLY];
    logic [LCT_DLY-1:0] r_dsf;
    logic [AW-1:0] r_rd, r_wr, r_icnt, w_wdat;
    logic w_run, w_init_done, w_shift, w_adv, w_rel_ok, w_err, w_pop, w_byp, w_push, w_wen;

    always_comb begin
        w_run       = r_state == S_RUN;
        w_init_done = !w_run && r_icnt == AW'(NBLK-1);
        w_state_nxt = w_init_done ? S_RUN : r_state;
        w_shift     = w_run && ENAREG;
        w_adv       = w_shift && !HOLD;
        w_rel_ok    = w_run && REL_VLD && BUSY_MAP[REL_ADR] && REL_ADR != WADR;
        w_err       = w_run && REL_VLD && !w_rel_ok;
        w_pop       = w_adv && NFREE != '0;
        // With nothing free, a release at the boundary becomes the new block directly
        w_byp       = w_adv && NFREE == '0 && w_rel_ok;
        w_push      = w_rel_ok && !w_byp;
        w_wen       = !w_run || w_push;
        w_wdat      = w_run ? REL_ADR : r_icnt;
    end

    assign SCAFULL     = w_run && NFREE == '0;
    assign ALMOST_FULL = w_run && NFREE <= (AW+1)'(AFULL_THR);
    assign LCTADR      = r_lct[LCT_DLY-1];
    assign DSCAFULL    = r_dsf[LCT_DLY-1];

    always_ff @(posedge CLK) begin
        if (w_wen) r_fifo[r_wr] <= w_wdat;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state  <= S_INIT;
            WADR     <= '0;
            NFREE    <= '0;
            READY    <= 1'b0;
            REL_ERR  <= 1'b0;
            BUSY_MAP <= NBLK'(1);
            r_rd     <= '0;
            r_wr     <= '0;
            r_icnt   <= AW'(1);
            r_dsf    <= '0;
            for (int i = 0; i < LCT_DLY; i++) r_lct[i] <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (!w_run) r_icnt <= r_icnt + 1'b1;
            if (w_init_done) READY <= 1'b1;
            if (w_wen) r_wr <= r_wr + 1'b1;
            if (w_pop) r_rd <= r_rd + 1'b1;
            if (w_pop) WADR <= r_fifo[r_rd];
            else if (w_byp) WADR <= REL_ADR;
            NFREE <= !w_run ? NFREE + 1'b1 : NFREE + (AW+1)'(w_push) - (AW+1)'(w_pop);
            BUSY_MAP <= (BUSY_MAP & ~(w_push ? NBLK'(1) << REL_ADR : '0))
                      | (w_pop ? NBLK'(1) << r_fifo[r_rd] : '0);
            if (w_err) REL_ERR <= 1'b1;
            if (w_shift) begin
                r_lct[0] <= WADR;
                r_dsf[0] <= SCAFULL;
                for (int i = 1; i < LCT_DLY; i++) begin
                    r_lct[i] <= r_lct[i-1];
                    r_dsf[i] <= r_dsf[i-1];
                end
            end
        end
    end
endmodule

// File: tb/tb_sca_blk_alloc.sv
// tb_sca_blk_alloc: directed checks on a 16-block allocator and randomized model checks on a 64-block one.
module tb_sca_blk_alloc;
    logic clk = 0;
    always #5 clk = ~clk;

    logic a_rst = 1, a_ena = 0, a_hold = 0, a_rv = 0;
    logic [3:0] a_ra = 0, a_wadr, a_lct;
    logic [4:0] a_nfree;
    logic a_sf, a_af, a_dsf, a_rdy, a_err;
    logic [15:0] a_busy;

    logic b_rst = 1, b_ena = 0, b_hold = 0, b_rv = 0;
    logic [5:0] b_ra = 0, b_wadr, b_lct;
    logic [6:0] b_nfree;
    logic b_sf, b_af, b_dsf, b_rdy, b_err;
    logic [63:0] b_busy;

    int n_chk = 0, n_pass = 0;

    sca_blk_alloc u16 (.CLK(clk), .RST(a_rst), .ENAREG(a_ena), .HOLD(a_hold), .REL_VLD(a_rv),
        .REL_ADR(a_ra), .WADR(a_wadr), .LCTADR(a_lct), .NFREE(a_nfree), .SCAFULL(a_sf),
        .ALMOST_FULL(a_af), .DSCAFULL(a_dsf), .READY(a_rdy), .REL_ERR(a_err), .BUSY_MAP(a_busy));

    sca_blk_alloc #(.NBLK(64), .AW(6)) u64 (.CLK(clk), .RST(b_rst), .ENAREG(b_ena), .HOLD(b_hold),
        .REL_VLD(b_rv), .REL_ADR(b_ra), .WADR(b_wadr), .LCTADR(b_lct), .NFREE(b_nfree),
        .SCAFULL(b_sf), .ALMOST_FULL(b_af), .DSCAFULL(b_dsf), .READY(b_rdy), .REL_ERR(b_err),
        .BUSY_MAP(b_busy));

    int m_q[$];
    int m_lct[$];
    bit m_dsf[$];
    bit [63:0] m_busy;
    int m_wadr, m_icnt, m_n;
    bit m_err, m_ready;

    function automatic void m_reset(int n);
        m_n = n; m_q.delete(); m_lct = '{0, 0, 0}; m_dsf = '{0, 0, 0};
        m_busy = 64'h1; m_wadr = 0; m_icnt = 1; m_err = 0; m_ready = 0;
    endfunction

    function automatic void m_step(bit ena, bit hold, bit rv, int ra);
        bit full, ok;
        if (!m_ready) begin
            m_q.push_back(m_icnt);
            m_icnt++;
            if (m_icnt == m_n) m_ready = 1;
            return;
        end
        full = m_q.size() == 0;
        ok = rv && m_busy[ra] && ra != m_wadr;
        if (rv && !ok) m_err = 1;
        if (ena) begin
            m_lct.push_back(m_wadr); void'(m_lct.pop_front());
            m_dsf.push_back(full); void'(m_dsf.pop_front());
        end
        if (ena && !hold) begin
            if (!full) begin
                m_wadr = m_q.pop_front();
                m_busy[m_wadr] = 1;
            end else if (ok) begin
                m_wadr = ra;
                ok = 0;
            end
        end
        if (ok) begin
            m_q.push_back(ra);
            m_busy[ra] = 0;
        end
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_init();
        a_rst = 1; #2; a_rst = 0;
        repeat (15) tick();
    endtask

    task automatic test_reset();
        tick(); a_rst = 1; #2;
        n_chk++;
        if ({a_wadr, a_lct, a_nfree, a_sf, a_af, a_dsf, a_rdy, a_err, a_busy} !== {4'd0, 4'd0, 5'd0, 5'b0, 16'h0001})
            $display("FAIL reset: got %h %h %h %b%b%b%b%b %h, need all 0 and busy 0001",
                a_wadr, a_lct, a_nfree, a_sf, a_af, a_dsf, a_rdy, a_err, a_busy);
        else n_pass++;
    endtask

    task automatic test_init();
        int cnt = 0;
        a_rst = 0; a_ena = 1; a_rv = 1; a_ra = 3;
        while (!a_rdy && cnt < 40) begin tick(); cnt++; end
        a_ena = 0; a_rv = 0;
        n_chk++; if (cnt !== 15) $display("FAIL init_cycles: got %0d need 15", cnt); else n_pass++;
        n_chk++; if (a_nfree !== 5'd15) $display("FAIL init_nfree: got %0d need 15", a_nfree); else n_pass++;
        n_chk++; if (a_wadr !== 4'd0) $display("FAIL init_wadr: got %0d need 0", a_wadr); else n_pass++;
        n_chk++; if (a_busy !== 16'h0001) $display("FAIL init_busy: got %h need 0001", a_busy); else n_pass++;
        n_chk++; if (a_err !== 1'b0) $display("FAIL init_err: got %b need 0", a_err); else n_pass++;
    endtask

    task automatic test_alloc();
        for (int i = 1; i <= 3; i++) begin
            a_ena = 1; tick();
            n_chk++; if (a_wadr !== 4'(i)) $display("FAIL alloc_wadr%0d: got %0d need %0d", i, a_wadr, i); else n_pass++;
        end
        a_ena = 0;
        n_chk++; if (a_nfree !== 5'd12) $display("FAIL alloc_nfree: got %0d need 12", a_nfree); else n_pass++;
        n_chk++; if (a_lct !== 4'd0) $display("FAIL alloc_lct3: got %0d need 0", a_lct); else n_pass++;
        a_ena = 1; tick(); a_ena = 0;
        n_chk++; if (a_wadr !== 4'd4) $display("FAIL alloc_wadr4: got %0d need 4", a_wadr); else n_pass++;
        n_chk++; if (a_lct !== 4'd1) $display("FAIL alloc_lct4: got %0d need 1", a_lct); else n_pass++;
    endtask

    task automatic test_full();
        for (int b = 5; b <= 18; b++) begin
            a_ena = 1; tick();
            n_chk++;
            if (a_wadr !== 4'(b <= 15 ? b : 15)) $display("FAIL full_wadr%0d: got %0d need %0d", b, a_wadr, b <= 15 ? b : 15);
            else n_pass++;
            if (b == 12) begin n_chk++; if (a_af !== 1'b0) $display("FAIL afull_nfree3: got %b need 0", a_af); else n_pass++; end
            if (b == 13) begin n_chk++; if ({a_af, a_nfree} !== {1'b1, 5'd2}) $display("FAIL afull_nfree2: got af=%b nfree=%0d need 1,2", a_af, a_nfree); else n_pass++; end
            if (b == 14) begin n_chk++; if (a_sf !== 1'b0) $display("FAIL scafull_early: got %b need 0", a_sf); else n_pass++; end
            if (b == 15) begin n_chk++; if ({a_sf, a_nfree} !== {1'b1, 5'd0}) $display("FAIL scafull: got sf=%b nfree=%0d need 1,0", a_sf, a_nfree); else n_pass++; end
            if (b == 17) begin n_chk++; if (a_dsf !== 1'b0) $display("FAIL dscafull_early: got %b need 0", a_dsf); else n_pass++; end
            if (b == 18) begin n_chk++; if (a_dsf !== 1'b1) $display("FAIL dscafull: got %b need 1", a_dsf); else n_pass++; end
        end
        a_ena = 0;
    endtask

    task automatic test_bypass();
        a_ena = 1; a_rv = 1; a_ra = 4; tick(); a_ena = 0; a_rv = 0;
        n_chk++;
        if ({a_wadr, a_nfree, a_err, a_busy} !== {4'd4, 5'd0, 1'b0, 16'hFFFF})
            $display("FAIL bypass: got wadr=%0d nfree=%0d err=%b busy=%h need 4,0,0,ffff", a_wadr, a_nfree, a_err, a_busy);
        else n_pass++;
    endtask

    task automatic test_double_rel();
        a_rv = 1; a_ra = 5; tick();
        n_chk++;
        if ({a_nfree, a_err, a_busy} !== {5'd1, 1'b0, 16'hFFDF})
            $display("FAIL rel5_first: got nfree=%0d err=%b busy=%h need 1,0,ffdf", a_nfree, a_err, a_busy);
        else n_pass++;
        tick(); a_rv = 0;
        n_chk++;
        if ({a_nfree, a_err} !== {5'd1, 1'b1})
            $display("FAIL rel5_second: got nfree=%0d err=%b need 1,1", a_nfree, a_err);
        else n_pass++;
    endtask

    task automatic test_hold();
        do_init();
        a_ena = 1; a_hold = 1; tick();
        n_chk++;
        if ({a_wadr, a_nfree, a_busy} !== {4'd0, 5'd15, 16'h0001})
            $display("FAIL hold: got wadr=%0d nfree=%0d busy=%h need 0,15,0001", a_wadr, a_nfree, a_busy);
        else n_pass++;
        a_hold = 0; tick(); a_ena = 0;
        n_chk++; if (a_wadr !== 4'd1) $display("FAIL after_hold: got %0d need 1", a_wadr); else n_pass++;
    endtask

    task automatic test_rel_wadr();
        a_rv = 1; a_ra = 1; tick(); a_rv = 0;
        n_chk++;
        if ({a_err, a_nfree, a_busy} !== {1'b1, 5'd14, 16'h0003})
            $display("FAIL rel_wadr: got err=%b nfree=%0d busy=%h need 1,14,0003", a_err, a_nfree, a_busy);
        else n_pass++;
    endtask

    task automatic test_random64();
        int bnd = 0, cyc = 0, ra;
        logic [88:0] exp_v;
        m_reset(64);
        b_rst = 0;
        while (bnd < 200 && cyc < 5000) begin
            b_ena = ($urandom_range(0, 9) < 7);
            b_hold = ($urandom_range(0, 9) == 0);
            b_rv = ($urandom_range(0, 9) < 4);
            ra = $urandom_range(0, 63);
            if ($urandom_range(0, 9) < 8)
                for (int k = 0; k < 64; k++)
                    if (m_busy[(ra + k) % 64]) begin ra = (ra + k) % 64; break; end
            b_ra = 6'(ra);
            m_step(b_ena, b_hold, b_rv, ra);
            if (m_ready && b_rdy && b_ena) bnd++;
            tick(); cyc++;
            exp_v = {6'(m_wadr), 6'(m_lct[0]), 7'(m_q.size()), m_ready && m_q.size() == 0,
                     m_ready && m_q.size() <= 2, m_dsf[0], m_ready, m_err, m_busy};
            n_chk++;
            if ({b_wadr, b_lct, b_nfree, b_sf, b_af, b_dsf, b_rdy, b_err, b_busy} !== exp_v)
                $display("FAIL rand64 cyc%0d: got %h need %h", cyc,
                    {b_wadr, b_lct, b_nfree, b_sf, b_af, b_dsf, b_rdy, b_err, b_busy}, exp_v);
            else n_pass++;
            if (b_rdy) begin
                n_chk++;
                if (32'(b_nfree) + $countones(b_busy) !== 64)
                    $display("FAIL conserve cyc%0d: got %0d need 64", cyc, 32'(b_nfree) + $countones(b_busy));
                else n_pass++;
            end
        end
        n_chk++; if (bnd < 200) $display("FAIL rand64_budget: got %0d boundaries need 200", bnd); else n_pass++;
        b_ena = 0; b_rv = 0; b_hold = 0;
        #3 b_rst = 1; #1;
        n_chk++;
        if ({b_wadr, b_lct, b_nfree, b_sf, b_af, b_dsf, b_rdy, b_err, b_busy} !== {6'd0, 6'd0, 7'd0, 5'b0, 64'h1})
            $display("FAIL rand64_reset: got %h %h %h %b%b%b%b%b %h need zeros and busy 1",
                b_wadr, b_lct, b_nfree, b_sf, b_af, b_dsf, b_rdy, b_err, b_busy);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_init();
        test_alloc();
        test_full();
        test_bypass();
        test_double_rel();
        test_hold();
        test_rel_wadr();
        test_random64();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/sca_blk_alloc.md
Name: sca_blk_alloc

Overview:
- Parametrised successor to the fixed 16-block SCA next-block allocator.
- Keeps a free-list FIFO of SCA block addresses and an in-use bitmap.
- Hands the next free block to the write pointer at each block boundary, accepts block releases from readout, and delays the current block address by LCT_DLY boundaries for LCT capture.
- Sits between the SCA write-address counter and the L1A/readout control; adds depth genericity, explicit release, double-release detection and an almost-full threshold.

Parameters:
NBLK, 16, number of SCA blocks; must be a power of 2, 4..64.
AW, 4, block address width; must equal log2(NBLK).
LCT_DLY, 3, boundary-pipeline depth from WADR to LCTADR; range 1..8.
AFULL_THR, 2, ALMOST_FULL asserts when NFREE <= AFULL_THR.

Ports:
CLK  in  1  system clock.
RST  in  1  asynchronous active-high reset.
ENAREG  in  1  block-boundary strobe; advance request.
HOLD  in  1  when 1 at a boundary, keep the current block; no pop, the block stays owned.
REL_VLD  in  1  release strobe from readout.
REL_ADR  in  AW  block being released.
WADR  out  AW  current write block.
LCTADR  out  AW  WADR delayed by LCT_DLY boundaries.
NFREE  out  AW+1  free-list occupancy.
SCAFULL  out  1  free list empty (NFREE==0).
ALMOST_FULL  out  1  NFREE <= AFULL_THR.
DSCAFULL  out  1  SCAFULL sampled at boundaries, delayed LCT_DLY boundaries.
READY  out  1  initialisation complete.
REL_ERR  out  1  sticky; release of a block not in use, or release of the current WADR.
BUSY_MAP  out  NBLK  in-use bitmap; bit i=1 means block i is owned.

Behaviour:
- Reset (async): state INIT; WADR=0; all LCTADR pipe stages=0; NFREE=0; SCAFULL=0 (forced 0 during INIT); ALMOST_FULL=0; DSCAFULL=0; READY=0; REL_ERR=0; BUSY_MAP=1 (block 0 owned); write pointer=0; init counter=1.
- FSM INIT:
  - One push per cycle of addresses 1..NBLK-1, ascending.
  - After NBLK-1 cycles: NFREE=NBLK-1, READY=1, go to RUN.
  - ENAREG and REL_VLD are ignored in INIT; REL_ERR is not set.
- FSM RUN, at ENAREG=1 with HOLD=0 and NFREE>0:
  - WADR <= FIFO head (registered, 1-cycle latency); pop; the BUSY_MAP bit for the new block is set.
  - The old block stays owned until released.
- FSM RUN, at ENAREG=1 with NFREE==0 (SCAFULL) or HOLD=1: WADR unchanged, no pop. A full condition never overwrites an owned block.
- LCT pipeline and DSCAFULL shift only on ENAREG=1 (including HOLD/full boundaries). LCTADR = stage LCT_DLY.
- Release, REL_VLD=1:
  - If BUSY_MAP[REL_ADR]=1 and REL_ADR!=WADR: push REL_ADR at the tail; clear the bit.
  - Otherwise: ignore the push and set REL_ERR.
- Simultaneous pop and valid push: NFREE unchanged. If NFREE==0, a release on the same cycle as ENAREG is bypassed directly to WADR; the bit stays set and NFREE stays 0.
- Release of the block being popped this same cycle is impossible, because that block is free; it sets REL_ERR.
- FIFO pointers wrap modulo NBLK. NFREE never exceeds NBLK-1, because WADR is always owned.
- SCAFULL and ALMOST_FULL are combinational from registered NFREE.
- RST asserted mid-operation aborts everything and returns to INIT with the values above.

Test Plan:
1. Reset, run 20 cycles idle -> READY rises at cycle 15; NFREE=15; WADR=0; BUSY_MAP=16'h0001.
2. After init, 3 boundaries with no release -> WADR=1,2,3; NFREE=12; LCTADR (LCT_DLY=3) = 0 after the third boundary, 1 after the fourth.
3. 15 boundaries without release -> SCAFULL=1 and WADR=15; a 16th boundary leaves WADR=15; ALMOST_FULL asserts at NFREE=2; DSCAFULL=1 three boundaries after SCAFULL.
4. While full, REL_VLD with REL_ADR=4 on the same cycle as ENAREG -> WADR=4 next cycle; NFREE stays 0; REL_ERR=0.
5. Release 5 twice -> second release sets REL_ERR=1; NFREE increments only once. Release of the current WADR also sets REL_ERR.
6. NBLK=64, AW=6: full allocate/release cycle of 200 boundaries with random releases -> NFREE + popcount(BUSY_MAP) == 64 every cycle; assert RST mid-run -> all outputs return to reset values immediately.
